// File: rtl/table_ad_arbiter_pkg.sv
// Shared types for the table-write arbiter: FSM encoding, the minimum
// write-strobe spacing, and the address-word layout seen by requesters and transmitter.
package table_ad_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int GAP_MIN = 6;

  typedef struct packed {
    logic [7:0]  chn;
    logic [23:0] addr;
  } tbl_addr_t;

  function automatic logic [31:0] mk_addr(input logic [7:0] chn, input logic [23:0] addr);
    tbl_addr_t w;
    w.chn  = chn;
    w.addr = addr;
    return w;
  endfunction

endpackage

// File: rtl/table_ad_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after last_i, wrapping; purely combinational.
module table_ad_arbiter_rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int REQ_BITS = 2
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [REQ_BITS-1:0] last_i,
  output logic [REQ_BITS-1:0] win_o,
  output logic                any_o
);

  logic [REQ_BITS-1:0] idx;

  // Scan from the farthest candidate down so the nearest one after last_i wins.
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = REQ_BITS'((int'(last_i) + k) % NUM_REQ);
      if (req_i[idx]) begin
        win_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/table_ad_arbiter.sv
// Shares one table_ad_transmit among NUM_REQ burst requesters; grant held per burst.
// Decision at edge t, we/ack registered at t+1; we pulses spaced >= GAP_CYCLES apart.
module table_ad_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int REQ_BITS   = 2,
  parameter int GAP_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [NUM_REQ-1:0]    req_a_not_d,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    ack,
  input  logic                  err_clr,
  output logic                  we,
  output logic                  a_not_d,
  output logic [31:0]           dout,
  output logic                  busy,
  output logic                  seq_err
);
  import table_ad_arbiter_pkg::*;

  // The transmitter cannot serialize faster than GAP_MIN, so never space tighter.
  localparam int         GAP_EFF = (GAP_CYCLES < GAP_MIN) ? GAP_MIN : GAP_CYCLES;
  localparam logic [3:0] GAP_RLD = 4'(GAP_EFF - 1);

  state_t              state_q;
  logic [REQ_BITS-1:0] grant_q;
  logic [REQ_BITS-1:0] last_grant_q;
  logic                first_word_q;
  logic [3:0]          gap_cnt_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                we_q;
  logic                a_not_d_q;
  logic [31:0]         dout_q;
  logic                seq_err_q;

  logic [REQ_BITS-1:0] pick_win;
  logic                pick_any;
  logic                issue;
  logic                fwd;
  logic [31:0]         sel_dat;
  logic [NUM_REQ-1:0]  grant_oh;

  table_ad_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .REQ_BITS(REQ_BITS)
  ) u_pick (
    .req_i (req_valid),
    .last_i(last_grant_q),
    .win_o (pick_win),
    .any_o (pick_any)
  );

  assign sel_dat  = req_data[{grant_q, 5'b0} +: 32];
  assign grant_oh = NUM_REQ'(1) << grant_q;
  assign issue    = (state_q == BUSY) && (gap_cnt_q == 4'd0) && req_valid[grant_q];
  // A burst must open with an address word; a leading data word is dropped.
  assign fwd      = !first_word_q || req_a_not_d[grant_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= REQ_BITS'(NUM_REQ - 1);
      first_word_q <= 1'b0;
      gap_cnt_q    <= '0;
      ack_q        <= '0;
      we_q         <= 1'b0;
      a_not_d_q    <= 1'b0;
      dout_q       <= '0;
      seq_err_q    <= 1'b0;
    end else begin
      ack_q <= '0;
      we_q  <= 1'b0;
      if (err_clr) seq_err_q <= 1'b0;
      if (gap_cnt_q != 4'd0) gap_cnt_q <= gap_cnt_q - 4'd1;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q      <= pick_win;
            first_word_q <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (issue) begin
            ack_q        <= grant_oh;
            gap_cnt_q    <= GAP_RLD;
            first_word_q <= 1'b0;
            if (fwd) begin
              we_q      <= 1'b1;
              a_not_d_q <= req_a_not_d[grant_q];
              dout_q    <= sel_dat;
            end else begin
              seq_err_q <= 1'b1;
            end
            if (req_last[grant_q]) begin
              state_q      <= IDLE;
              last_grant_q <= grant_q;
            end
          end
        end
      endcase
    end
  end

  assign ack     = ack_q;
  assign we      = we_q;
  assign a_not_d = a_not_d_q;
  assign dout    = dout_q;
  assign busy    = (state_q == BUSY);
  assign seq_err = seq_err_q;

endmodule

// File: tb/tb_table_ad_arbiter.sv
// Scoreboard bench: scenarios push expected issues, a monitor pops them on every ack/we.
module tb_table_ad_arbiter;
  import table_ad_arbiter_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid, req_last, req_a_not_d;
  logic [32*N-1:0] req_data;
  logic           err_clr;
  logic           sel8;

  logic [N-1:0] ack6, ack8, ack_m;
  logic         we6, we8, we_m, and6, and8, and_m, busy6, busy8, busy_m, err6, err8, err_m;
  logic [31:0]  dout6, dout8, dout_m;
  int           gap_m;

  always #5 clk = ~clk;

  table_ad_arbiter #(.NUM_REQ(N), .REQ_BITS(2), .GAP_CYCLES(6)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_a_not_d(req_a_not_d), .req_data(req_data), .ack(ack6), .err_clr(err_clr),
    .we(we6), .a_not_d(and6), .dout(dout6), .busy(busy6), .seq_err(err6));

  table_ad_arbiter #(.NUM_REQ(N), .REQ_BITS(2), .GAP_CYCLES(8)) dut8 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_a_not_d(req_a_not_d), .req_data(req_data), .ack(ack8), .err_clr(err_clr),
    .we(we8), .a_not_d(and8), .dout(dout8), .busy(busy8), .seq_err(err8));

  assign ack_m  = sel8 ? ack8  : ack6;
  assign we_m   = sel8 ? we8   : we6;
  assign and_m  = sel8 ? and8  : and6;
  assign dout_m = sel8 ? dout8 : dout6;
  assign busy_m = sel8 ? busy8 : busy6;
  assign err_m  = sel8 ? err8  : err6;
  assign gap_m  = sel8 ? 8 : 6;

  typedef struct {logic a; logic last; logic [31:0] d;} word_t;
  typedef struct {int idx; logic we; logic a; logic [31:0] d; int exact;} exp_t;

  word_t      rq[N][$];
  exp_t       expq[$];
  logic [N-1:0] hold;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic ld(input int i, input logic a, input logic last, input logic [31:0] d);
    rq[i].push_back('{a, last, d});
  endtask

  task automatic ex(input int idx, input logic w, input logic a, input logic [31:0] d, input int exact);
    expq.push_back('{idx, w, a, d, exact});
  endtask

  function automatic bit rq_pending();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Requester model: pops the presented word on ack, presents the next from the following cycle.
  initial begin
    req_valid = '0; req_last = '0; req_a_not_d = '0; req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst && ack_m[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        if (rq[i].size() != 0 && !hold[i]) begin
          req_valid[i]         = 1'b1;
          req_last[i]          = rq[i][0].last;
          req_a_not_d[i]       = rq[i][0].a;
          req_data[32*i +: 32] = rq[i][0].d;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: every ack/we must match the next expected issue, in order.
  int cyc = 0;
  int last_ack = 0;
  int last_we = 0;
  bit have_we = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        have_we = 1'b0;
      end else if (ack_m != '0 || we_m) begin
        if (expq.size() == 0) begin
          chk("unexpected_issue", {27'd0, we_m, ack_m}, 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("ack", {28'd0, ack_m}, 32'd1 << e.idx);
          chk("we", {31'd0, we_m}, {31'd0, e.we});
          if (e.we) begin
            chk("a_not_d", {31'd0, and_m}, {31'd0, e.a});
            chk("dout", dout_m, e.d);
          end
          if (e.exact > 0) chk("ack_interval", cyc - last_ack, e.exact);
        end
        if (we_m && have_we) chk("we_interval_ge_gap", {31'd0, (cyc - last_we) >= gap_m}, 32'd1);
        last_ack = cyc;
        if (we_m) begin
          last_we = cyc;
          have_we = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    expq.delete();
    hold = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((expq.size() != 0 || rq_pending()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout pending_exp=%0d required=0", name, expq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ack(input int idx, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_m[idx] && n < 500);
    if (!ack_m[idx]) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout ack=%b required_bit=%0d", name, ack_m, idx);
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0;
    err_clr = 1'b0; sel8 = 1'b0; hold = '0;

    // Reset state
    @(negedge clk);
    chk("rst_we", {31'd0, we6}, 32'd0);
    chk("rst_a_not_d", {31'd0, and6}, 32'd0);
    chk("rst_dout", dout6, 32'd0);
    chk("rst_ack", {28'd0, ack6}, 32'd0);
    chk("rst_busy", {31'd0, busy6}, 32'd0);
    chk("rst_seq_err", {31'd0, err6}, 32'd0);
    do_reset();

    // Single burst from req0
    a0 = mk_addr(8'h02, 24'h000010);
    ex(0, 1, 1, a0, 0); ex(0, 1, 0, 32'h11111111, 6); ex(0, 1, 0, 32'h22222222, 6);
    ld(0, 1, 0, a0); ld(0, 0, 0, 32'h11111111); ld(0, 0, 1, 32'h22222222);
    repeat (5) @(negedge clk);
    chk("s1_busy_mid", {31'd0, busy6}, 32'd1);
    drain("s1");
    chk("s1_busy_end", {31'd0, busy6}, 32'd0);

    // Round-robin between req1 and req3
    do_reset();
    ex(1, 1, 1, 32'h01000001, 0); ex(3, 1, 1, 32'h03000003, 6);
    ex(1, 1, 1, 32'h01000101, 6); ex(3, 1, 1, 32'h03000303, 6);
    ld(1, 1, 1, 32'h01000001); ld(1, 1, 1, 32'h01000101);
    ld(3, 1, 1, 32'h03000003); ld(3, 1, 1, 32'h03000303);
    drain("s2a");

    // last_grant=1 with req0/1/3 valid -> 3, 0, 1
    do_reset();
    ex(1, 1, 1, 32'h01AAAAAA, 0);
    ld(1, 1, 1, 32'h01AAAAAA);
    drain("s2b_pre");
    ex(3, 1, 1, 32'h03BBBBBB, 0); ex(0, 1, 1, 32'h00CCCCCC, 6); ex(1, 1, 1, 32'h01DDDDDD, 6);
    ld(0, 1, 1, 32'h00CCCCCC); ld(1, 1, 1, 32'h01DDDDDD); ld(3, 1, 1, 32'h03BBBBBB);
    drain("s2b");

    // Granted req2 stalls after its address while req0 waits
    do_reset();
    ex(2, 1, 1, 32'h02000200, 0); ex(2, 1, 0, 32'hA2A2A2A2, 0);
    ex(2, 1, 0, 32'hB2B2B2B2, 6); ex(0, 1, 1, 32'h00000040, 6);
    ld(2, 1, 0, 32'h02000200); ld(2, 0, 0, 32'hA2A2A2A2); ld(2, 0, 1, 32'hB2B2B2B2);
    wait_ack(2, "s3_addr");
    hold[2] = 1'b1;
    ld(0, 1, 1, 32'h00000040);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("s3_stall_quiet", {27'd0, we_m, ack_m}, 32'd0);
    end
    chk("s3_busy_held", {31'd0, busy6}, 32'd1);
    hold[2] = 1'b0;
    drain("s3");

    // Burst opening with a data word
    do_reset();
    ex(1, 0, 0, 32'h0, 0); ex(1, 1, 1, 32'h03000020, 6); ex(1, 1, 0, 32'h33333333, 6);
    ld(1, 0, 0, 32'hDEADBEEF); ld(1, 1, 0, 32'h03000020); ld(1, 0, 1, 32'h33333333);
    drain("s4");
    chk("s4_seq_err_set", {31'd0, err6}, 32'd1);
    err_clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("s4_err_clr", {31'd0, err6}, 32'd0);
    ex(1, 0, 0, 32'h0, 0);
    ld(1, 0, 1, 32'h44444444);
    wait_ack(1, "s4_clr_collide");
    err_clr = 1'b0;
    chk("s4_set_over_clr", {31'd0, err6}, 32'd1);
    drain("s4b");

    // GAP_CYCLES=8, two 3-word bursts
    sel8 = 1'b1;
    do_reset();
    ex(0, 1, 1, 32'h00000100, 0); ex(0, 1, 0, 32'h0A0A0A0A, 8); ex(0, 1, 0, 32'h0B0B0B0B, 8);
    ex(1, 1, 1, 32'h01000100, 8); ex(1, 1, 0, 32'h1A1A1A1A, 8); ex(1, 1, 0, 32'h1B1B1B1B, 8);
    ld(0, 1, 0, 32'h00000100); ld(0, 0, 0, 32'h0A0A0A0A); ld(0, 0, 1, 32'h0B0B0B0B);
    ld(1, 1, 0, 32'h01000100); ld(1, 0, 0, 32'h1A1A1A1A); ld(1, 0, 1, 32'h1B1B1B1B);
    drain("s5");
    chk("s5_busy_end", {31'd0, busy_m}, 32'd0);
    chk("s5_seq_err", {31'd0, err_m}, 32'd0);
    sel8 = 1'b0;

    // Asynchronous reset while the second word is being issued
    do_reset();
    ex(0, 0, 0, 32'h0, 0); ex(0, 1, 1, 32'h00000300, 6);
    ld(0, 0, 0, 32'h55555555); ld(0, 1, 0, 32'h00000300); ld(0, 0, 1, 32'h66666666);
    wait_ack(0, "s6_first");
    wait_ack(0, "s6_second");
    chk("s6_pre_busy", {31'd0, busy6}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("s6_rst_we", {31'd0, we6}, 32'd0);
    chk("s6_rst_ack", {28'd0, ack6}, 32'd0);
    chk("s6_rst_busy", {31'd0, busy6}, 32'd0);
    chk("s6_rst_seq_err", {31'd0, err6}, 32'd0);
    for (int i = 0; i < N; i++) rq[i].delete();
    expq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ex(0, 1, 1, 32'h00000400, 0); ex(3, 1, 1, 32'h03000400, 6);
    ld(3, 1, 1, 32'h03000400); ld(0, 1, 1, 32'h00000400);
    drain("s6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/table_ad_arbiter.md
Name: table_ad_arbiter

Overview:
Shares one table_ad_transmit instance between NUM_REQ table-write requesters, such as per-channel compressor, sensor LUT and histogram setup sequencers. Each requester presents bursts made of one address word followed by data words. The block picks a requester round-robin at burst boundaries, holds the grant for the whole burst, and issues single-cycle we pulses spaced at least GAP_CYCLES apart, as the transmitter's serialization requires.

Parameters:
NUM_REQ, 4, number of requesters
REQ_BITS, 2, width of the grant index; 2**REQ_BITS >= NUM_REQ
GAP_CYCLES, 6, minimum clk cycles between consecutive we pulses; legal range 6..15

Ports:
clk  in  1  posedge mclk
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a word pending; held until ack[i]
req_last  in  NUM_REQ  pending word is the last of the burst
req_a_not_d  in  NUM_REQ  pending word is an address word (chn[31:24], byte addr[23:0])
req_data  in  32*NUM_REQ  pending word of requester i, in bits [32*i+:32]
ack  out  NUM_REQ  one-cycle pulse: word consumed, requester may present the next word from the following cycle
err_clr  in  1  clears seq_err
we  out  1  to the transmitter; single-cycle write strobe
a_not_d  out  1  to the transmitter; valid while we=1
dout  out  32  to the transmitter; valid while we=1
busy  out  1  a grant is held (state BUSY)
seq_err  out  1  sticky: a burst started with a data word

Behaviour:
- Reset: we=0, a_not_d=0, dout=0, ack=0, busy=0, seq_err=0, state=IDLE, gap_cnt=0, last_grant=NUM_REQ-1.
- States: IDLE and BUSY. first_word flag is set on entry to BUSY.
- IDLE: if req_valid!=0, pick the first valid index strictly after last_grant, wrapping modulo NUM_REQ. Register grant, go to BUSY, set first_word=1. Nothing is issued in that cycle.
- Arbitration does not wait for the gap: gap_cnt keeps counting down in IDLE.
- BUSY, issue condition: gap_cnt==0 and req_valid[grant]. At the next edge:
  - ack[grant]=1;
  - gap_cnt=GAP_CYCLES-1.
- Forwarded word (first_word=0, or req_a_not_d[grant]=1):
  - we=1 in the same cycle as ack;
  - dout=req_data[grant];
  - a_not_d=req_a_not_d[grant].
- Discarded word (first_word=1 and req_a_not_d[grant]=0):
  - ack is still given, no we;
  - seq_err is set;
  - the burst proceeds and later words are forwarded normally.
- first_word clears on the first issue.
- Address words later in a burst are legal: they re-address the same burst.
- If the issued word has req_last=1: state=IDLE, last_grant=grant, busy=0 from the next cycle.
- The decision is combinational from inputs sampled at edge t; we and ack are visible t+1. Requesters update req_* at t+2 at the earliest, and the arbiter does not sample again before t+GAP_CYCLES.
- Outputs outside an issue cycle: we and ack are 0. dout and a_not_d hold their last value.
- The we spacing guarantee holds across burst and requester changes: the interval between we pulses is always >= GAP_CYCLES.
- Granted requester drops req_valid mid-burst: the grant is held and nothing is issued. Other requesters wait. There is no timeout.
- req_valid of non-granted requesters changing during BUSY has no effect.
- seq_err: set has priority over err_clr in the same cycle.
- Single requester bursting back-to-back: it is re-granted through IDLE, so there is 1 arbitration cycle, hidden if gap_cnt>0.
- rst asserted mid-burst: immediate return to reset values. Any partially sent burst is the requester's responsibility to resend.

Decomposition:
- Shared package: state encoding (IDLE, BUSY), GAP_MIN=6, and a table-address word field layout (channel [31:24], address [23:0]) for requesters and transmitter alike.
- One sub-module: rr_pick, a combinational round-robin priority picker. Inputs: request vector and last_grant. Outputs: winner index and any flag.

Test Plan:
- Single burst: req0 sends addr 0x0200_0010, then data 0x11111111, 0x22222222 (last) -> we at cycles t, t+6, t+12. dout matches, a_not_d=1,0,0. ack[0] coincides with each we. busy drops after the last word.
- Round-robin: req1 and req3 hold 1-word bursts (addr, last) from reset -> grants go 1, 3, 1, 3. With last_grant=1, req0/1/3 all valid -> order is 3, 0, 1.
- Stall: req2 drops valid for 20 cycles after the address while req0 is valid -> no we and no ack[0] during the stall. The burst resumes with req2's data; req0 is granted only after req2's last.
- Sequence error: req1 starts a burst with a data word 0xDEADBEEF -> ack[1] with we=0, seq_err=1. The following address word is forwarded. err_clr on the same cycle as a new violation -> seq_err stays 1.
- GAP_CYCLES=8, two requesters with 3-word bursts -> every we interval is >= 8, including the requester switch.
- rst pulse in the middle of the second word of a burst -> we, ack, busy and seq_err are 0 asynchronously. The next arbitration starts from index 0.
